pc_redirect_ctrl: RTL

//  Fetch-side consumer of the ID-stage branch unit's pc_taken/forwarding results: owns the PC register,

---
 rtl/pc_redirect_ctrl_if.sv | 31 +++
 rtl/pc_redirect_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// Signal bundle between the ID-stage branch unit / hazard sources and the fetch-side PC controller.
// The master side drives ID/EX/MEM status; the slave (pc_redirect_ctrl) returns PC and pipeline controls.
interface pc_redirect_ctrl_if;
  logic        i_hold;
  logic [6:0]  i_id_opcode;
  logic        i_id_brtaken;
  logic [31:0] i_pc_taken;
  logic [4:0]  i_ifid_rs1addr;
  logic [4:0]  i_ifid_rs2addr;
  logic [4:0]  i_idex_rdaddr;
  logic        i_idex_memrd;
  logic [4:0]  i_exmem_rdaddr;
  logic        i_exmem_memrd;
  logic [31:0] o_pc;
  logic        o_ifid_en;
  logic        o_ifid_flush;
  logic        o_idex_bubble;
  logic        o_misalign;

  modport master (
    output i_hold, i_id_opcode, i_id_brtaken, i_pc_taken, i_ifid_rs1addr, i_ifid_rs2addr,
           i_idex_rdaddr, i_idex_memrd, i_exmem_rdaddr, i_exmem_memrd,
    input  o_pc, o_ifid_en, o_ifid_flush, o_idex_bubble, o_misalign
  );

  modport slave (
    input  i_hold, i_id_opcode, i_id_brtaken, i_pc_taken, i_ifid_rs1addr, i_ifid_rs2addr,
           i_idex_rdaddr, i_idex_memrd, i_exmem_rdaddr, i_exmem_memrd,
    output o_pc, o_ifid_en, o_ifid_flush, o_idex_bubble, o_misalign
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: applies taken BRANCH/JAL/JALR redirects with a one-slot flush, and stalls IF/ID
// with ID/EX bubbles while a branch source is still being loaded from memory.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          LOAD_STALL = 2
) (
  input logic               i_clk,
  input logic               i_rst,
  pc_redirect_ctrl_if.slave bus
);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam int         CNT_W   = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

  typedef enum logic {RUN, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        pc;
  logic               misalign;

  logic        is_br, is_jal, is_jalr, rs1_used, rs2_used;
  logic        hit_ex, hit_mem, use_ex, use_mem, take, stall, redirect;
  logic [31:0] target;

  assign is_br    = (bus.i_id_opcode == OP_BR);
  assign is_jal   = (bus.i_id_opcode == OP_JAL);
  assign is_jalr  = (bus.i_id_opcode == OP_JALR);
  assign rs1_used = is_br | is_jalr;
  assign rs2_used = is_br;

  // x0 never carries a real dependency, so a zero source can never match.
  assign hit_ex  = (rs1_used && bus.i_ifid_rs1addr != 5'd0 && bus.i_ifid_rs1addr == bus.i_idex_rdaddr)
                || (rs2_used && bus.i_ifid_rs2addr != 5'd0 && bus.i_ifid_rs2addr == bus.i_idex_rdaddr);
  assign hit_mem = (rs1_used && bus.i_ifid_rs1addr != 5'd0 && bus.i_ifid_rs1addr == bus.i_exmem_rdaddr)
                || (rs2_used && bus.i_ifid_rs2addr != 5'd0 && bus.i_ifid_rs2addr == bus.i_exmem_rdaddr);
  assign use_ex  = hit_ex  & bus.i_idex_memrd;
  assign use_mem = hit_mem & bus.i_exmem_memrd;

  assign take   = is_jal | is_jalr | (is_br & bus.i_id_brtaken);
  assign target = is_jalr ? (bus.i_pc_taken & ~32'h1) : bus.i_pc_taken;

  // NOTE: continuous assigns give every control a value on every path, so no latch can form.
  assign stall    = !bus.i_hold && (state == HOLD || use_ex || use_mem);
  assign redirect = !bus.i_hold && state == RUN && !use_ex && !use_mem && take;

  assign bus.o_ifid_en     = !bus.i_hold && !stall;
  assign bus.o_ifid_flush  = redirect;
  assign bus.o_idex_bubble = stall;
  assign bus.o_pc          = pc;
  assign bus.o_misalign    = misalign;

  // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= RUN;
      cnt      <= '0;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (!bus.i_hold) begin
      case (state)
        RUN: begin
          if (use_ex) begin
            if (LOAD_STALL > 1) begin
              state <= HOLD;
              cnt   <= CNT_W'(LOAD_STALL - 2);
            end
          end else if (use_mem) begin
            // single stall; the load reaches WB next cycle and hazards are re-evaluated
          end else if (take) begin
            pc <= target;
            if (target[1]) misalign <= 1'b1;
          end else begin
            pc <= pc + 32'd4;
          end
        end
        HOLD: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
